// File: rtl/burst_fetch_unit.sv
// AXI instruction fetch engine: issues INCR line bursts, buffers beats,
// unpacks them into 32-bit instructions with PCs, handles redirect and halt.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no burst outstanding; wait for room for a whole burst
// AR     | arvalid asserted, address held until arready
// DATA   | burst in flight, beats pushed into the beat FIFO
// DRAIN  | burst in flight after redirect/halt, beats discarded
// HALT   | zero instruction seen; fetching stopped until reset
`timescale 1ns/1ps
module burst_fetch_unit #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_BEATS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] entry_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ID_WIDTH-1:0]   m_axi_arid_o,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [7:0]            m_axi_arlen_o,
    output logic [2:0]            m_axi_arsize_o,
    output logic [1:0]            m_axi_arburst_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic                  m_axi_rlast_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  halted_o
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int SLOTS      = DATA_WIDTH / 32;
    localparam int LINE       = BURST_LEN * BEAT_BYTES;
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);
    localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_W      = (FIFO_BEATS > 1) ? $clog2(FIFO_BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_DATA, S_DRAIN, S_HALT} state_e;

    function automatic logic [SLOT_W-1:0] slot_of(input logic [ADDR_WIDTH-1:0] pc);
        return SLOT_W'((pc >> 2) & ADDR_WIDTH'(SLOTS - 1));
    endfunction

    function automatic logic [8:0] beat_of(input logic [ADDR_WIDTH-1:0] pc);
        return 9'((pc & ADDR_WIDTH'(LINE - 1)) >> BEAT_SH);
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_q, fetch_d, araddr_q, araddr_d;
    logic [8:0]              skip_q, skip_d, beat_q, beat_d;
    logic                    drain_pend_q, drain_pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_BEATS];
    logic [PTR_W:0]          wptr_q, wptr_d, rptr_q, rptr_d, fifo_cnt;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [ADDR_WIDTH-1:0]   npc_q, npc_d, pc_q, pc_d;
    logic                    valid_q, valid_d, halted_q, halted_d;
    logic [31:0]             instr_q, instr_d, head_word;
    logic                    redir, r_hs, push, pop;

    assign m_axi_arid_o    = '0;
    assign m_axi_arlen_o   = 8'(BURST_LEN - 1);
    assign m_axi_arsize_o  = 3'(BEAT_SH);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_araddr_o  = araddr_q;
    assign m_axi_arvalid_o = (state_q == S_AR);
    assign m_axi_rready_o  = (state_q == S_DATA) || (state_q == S_DRAIN);
    assign instr_valid_o   = valid_q;
    assign instr_o         = instr_q;
    assign instr_pc_o      = pc_q;
    assign halted_o        = halted_q;

    // A halted unit ignores redirects entirely.
    assign redir     = redirect_valid_i && !halted_q;
    assign r_hs      = m_axi_rready_o && m_axi_rvalid_i;
    // Beats of the first line that sit wholly below the start PC never enter the FIFO.
    assign push      = (state_q == S_DATA) && r_hs && !redir && !halted_q && (beat_q >= skip_q);
    assign fifo_cnt  = wptr_q - rptr_q;
    assign head_word = mem_q[rptr_q[PTR_W-1:0]][32*int'(slot_q) +: 32];

    // Fetch FSM next state: burst issue, completion and drain decisions.
    always_comb begin
        state_d      = state_q;
        fetch_d      = fetch_q;
        araddr_d     = araddr_q;
        skip_d       = skip_q;
        beat_d       = beat_q;
        drain_pend_d = drain_pend_q;
        if (redir) fetch_d = redirect_pc_i;
        case (state_q)
            S_IDLE: begin
                if (halted_q) begin
                    state_d = S_HALT;
                end else if (!redir && fifo_cnt <= (PTR_W+1)'(FIFO_BEATS - BURST_LEN)) begin
                    state_d      = S_AR;
                    araddr_d     = fetch_q & LINE_MASK;
                    skip_d       = beat_of(fetch_q);
                    drain_pend_d = 1'b0;
                end
            end
            S_AR: begin
                // The address cannot be withdrawn; a redirect marks the burst for draining.
                if (redir) drain_pend_d = 1'b1;
                if (m_axi_arready_i) begin
                    beat_d  = '0;
                    state_d = (redir || drain_pend_q || halted_q) ? S_DRAIN : S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (m_axi_rlast_i) begin
                        state_d = S_IDLE;
                        // Next line follows the aligned line, so no skip applies to it.
                        if (!redir) fetch_d = araddr_q + ADDR_WIDTH'(LINE);
                    end else if (redir || halted_q) begin
                        state_d = S_DRAIN;
                    end
                end else if (redir || halted_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_hs && m_axi_rlast_i) state_d = S_IDLE;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Fetch FSM registers; fetch address loads from entry while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            fetch_q      <= entry_i;
            araddr_q     <= '0;
            skip_q       <= '0;
            beat_q       <= '0;
            drain_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_q      <= fetch_d;
            araddr_q     <= araddr_d;
            skip_q       <= skip_d;
            beat_q       <= beat_d;
            drain_pend_q <= drain_pend_d;
        end
    end

    // Unpacker: flush on redirect, else move the next head slot into the output register.
    always_comb begin
        pop      = 1'b0;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        slot_d   = slot_q;
        halted_d = halted_q;
        wptr_d   = wptr_q + (PTR_W+1)'(push);
        rptr_d   = rptr_q;
        if (redir) begin
            valid_d = 1'b0;
            npc_d   = redirect_pc_i;
            slot_d  = slot_of(redirect_pc_i);
            wptr_d  = '0;
        end else if (!halted_q && fifo_cnt != '0 && (!valid_q || instr_ready_i)) begin
            if (head_word == 32'h0) begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                instr_d = head_word;
                pc_d    = npc_q;
                npc_d   = npc_q + ADDR_WIDTH'(4);
                if (slot_q == SLOT_W'(SLOTS - 1)) begin
                    pop    = 1'b1;
                    slot_d = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
        end else if (valid_q && instr_ready_i) begin
            valid_d = 1'b0;
        end
        if (redir) rptr_d = '0;
        else if (pop) rptr_d = rptr_q + 1'b1;
    end

    // Unpacker, FIFO pointers and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            slot_q   <= slot_of(entry_i);
            npc_q    <= entry_i;
            pc_q     <= entry_i;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            slot_q   <= slot_d;
            npc_q    <= npc_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Beat storage; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[PTR_W-1:0]] <= m_axi_rdata_i;
    end

endmodule

// File: doc/burst_fetch_unit.md
# burst_fetch_unit

Parametrised AXI instruction fetch engine that replaces the fixed single-burst fetch loop in the front end. It does the following:
- Issues INCR read bursts of configurable length on the AR channel.
- Buffers returned beats in a credit-checked FIFO.
- Unpacks each beat into 32-bit instructions with their PCs, presented to decode over a valid/ready handshake.
- Supports a PC redirect that flushes buffered and in-flight data.
- Halts on an all-zero instruction word.

## Interface
Parameters:
- ID_WIDTH, 13, AXI ID width
- ADDR_WIDTH, 64, address/PC width
- DATA_WIDTH, 64, AXI data width; power of two, ≥ 32
- BURST_LEN, 8, beats per burst (1..256)
- FIFO_BEATS, 16, beat buffer depth; power of two, ≥ BURST_LEN

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- entry  in  ADDR_WIDTH  start PC; sampled while reset is low; bits [1:0] are zero
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] are zero
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst start address, aligned to LINE = BURST_LEN*DATA_WIDTH/8 bytes
- m_axi_arlen  out  8  constant BURST_LEN-1
- m_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address accept
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  data valid
- m_axi_rready  out  1  data accept
- instr_valid  out  1  instruction available
- instr_ready  in  1  decode accepts
- instr  out  32  instruction word
- instr_pc  out  ADDR_WIDTH  PC of instr
- halted  out  1  zero instruction reached; sticky until reset

## Operation
FSM states and transitions:
- IDLE: go to AR when FIFO free entries ≥ BURST_LEN and not halted.
- AR: arvalid=1; araddr/arlen stay stable until arready. On handshake, go to DATA.
- DATA: rready=1 in every cycle, because space was reserved. Each beat pushes into the FIFO. The beat with rlast returns to IDLE with fetch_addr += LINE, wrapping modulo 2^ADDR_WIDTH.
- DRAIN: rready=1; beats are discarded. rlast goes to IDLE.
- HALT: terminal state; no further AR is issued.

Addressing and unpacking:
- Line alignment: araddr = fetch_addr & ~(LINE-1).
- Slots of the first beat group that lie below the start PC are dropped, with no output. This covers beat index and word slot within the beat.
- The FIFO head beat is unpacked as word slot k = rdata[32k+31:32k], for k = 0..DATA_WIDTH/32-1, in ascending order. instr_pc advances +4 per slot.
- The head beat pops when its last slot is consumed.

Halt:
- If the head word is 32'h0, instr_valid stays 0 and halted goes to 1 the next cycle.
- The FSM enters HALT after any in-flight burst completes; that burst is drained.

Redirect:
- redirect_valid flushes the FIFO and unpacker in the same edge and sets fetch_addr = redirect_pc.
- From AR with arvalid not yet accepted: stay in AR. araddr changes only after the current handshake; the accepted burst is then drained.
- From AR with the handshake in the same cycle as the redirect: go to DRAIN.
- From DATA: go to DRAIN.
- From IDLE: stay in IDLE.
- A redirect during DRAIN updates fetch_addr only.
- Redirect has no effect once halted.

Free-entry count includes reserved-but-unreceived beats of the in-flight burst.

## Timing
- Reset values: arvalid=0, rready=0, instr_valid=0, halted=0, araddr=0, instr=0, instr_pc=entry. FSM=IDLE; FIFO empty.
- First arvalid is asserted in the 2nd cycle after reset deasserts: IDLE evaluates, then AR is registered.
- Beat accepted at edge N gives instr_valid=1 after edge N+1, when the FIFO was empty.
- Throughput is 1 instruction/cycle while the FIFO is non-empty and instr_ready=1.
- instr/instr_pc hold while instr_valid && !instr_ready.
- A redirect at edge N gives instr_valid=0 from edge N. The first new AR is issued after DRAIN completes.
- Simultaneous FIFO push and pop in one cycle are both honoured.
- Full FIFO: AR is withheld. Empty FIFO: instr_valid=0.
- Reset asserted mid-burst aborts immediately. The interconnect must also be reset; no drain is performed.

## Test plan
- Entry 0x8000_0000, defaults, memory holds words 0x1..0x20, ready always 1 -> AR araddr=0x8000_0000 arlen=7 arsize=3 arburst=1. Out: instr 0x1..0x10 with PCs 0x8000_0000..0x8000_003C, then second AR at 0x8000_0040.
- Entry 0x8000_0014 -> araddr=0x8000_0000. First instr_pc=0x8000_0014 (word 6); earlier slots are never presented.
- instr_ready=0 for 40 cycles -> exactly 2 bursts outstanding-and-buffered (FIFO_BEATS=16), no third AR. Resuming gives in-order output with no loss.
- redirect_pc=0x8000_1000 at beat 3 of a burst -> remaining 5 beats drained, no stale instr out. Next araddr=0x8000_1000.
- Word at 0x8000_0028 = 0 -> last instr_pc=0x8000_0024, halted=1, no further AR, redirect ignored.
- reset low mid-DATA with entry=0x9000_0000 -> all outputs at reset values. After release, AR araddr=0x9000_0000.
